// File: rtl/multicycle_control_unit_pkg.sv
// cu_pkg: shared definitions for the multicycle RV32I control unit.
//   state_t            : 3-bit FSM state encoding (also visible on state_o)
//   OP_*               : RV32I major opcodes recognised by the sequencer
//   ALU_*              : ALU operation codes shared with the datapath ALU
//   M2R_*/PCSRC_*      : MemtoReg and PCSrc mux select encodings
//   CAUSE_*            : trap_cause encodings
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;  // pass operand B (immediate)

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JAL    = 2'd2;
  localparam logic [1:0] PCSRC_JALR   = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: combinational decode of {opcode, func7, func3} into the ALU
// operation, the ALU operand selects and an illegal-instruction flag.
//   opcode/func7/func3 : fields of the registered instruction
//   alu_ctrl           : ALU_* operation
//   src_a              : 0 rs1, 1 PC
//   src_b              : 0 rs2, 1 immediate
//   illegal            : opcode unknown or R-type func7/func3 unsupported
module alu_decoder
  import cu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] func7,
  input  logic [2:0] func3,
  output logic [4:0] alu_ctrl,
  output logic       src_a,
  output logic       src_b,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_NOP;
    src_a    = 1'b0;
    src_b    = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        if (func7 == 7'b0000000) begin
          case (func3)
            3'd0:    alu_ctrl = ALU_ADD;
            3'd1:    alu_ctrl = ALU_SLL;
            3'd2:    alu_ctrl = ALU_SLT;
            3'd3:    alu_ctrl = ALU_SLTU;
            3'd4:    alu_ctrl = ALU_XOR;
            3'd5:    alu_ctrl = ALU_SRL;
            3'd6:    alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
          endcase
        end else if (func7 == 7'b0100000 && func3 == 3'd0) begin
          alu_ctrl = ALU_SUB;
        end else if (func7 == 7'b0100000 && func3 == 3'd5) begin
          alu_ctrl = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        src_b = 1'b1;
        case (func3)
          3'd0:    alu_ctrl = ALU_ADD;
          3'd1:    alu_ctrl = ALU_SLL;
          3'd2:    alu_ctrl = ALU_SLT;
          3'd3:    alu_ctrl = ALU_SLTU;
          3'd4:    alu_ctrl = ALU_XOR;
          // SRAI vs SRLI is carried in imm[10], which sits at func7[5]
          3'd5:    alu_ctrl = func7[5] ? ALU_SRA : ALU_SRL;
          3'd6:    alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        alu_ctrl = ALU_ADD;
        src_b    = 1'b1;
      end
      OP_BRANCH: alu_ctrl = ALU_SUB;
      OP_LUI: begin
        alu_ctrl = ALU_LUI;
        src_b    = 1'b1;
      end
      OP_AUIPC, OP_JAL: begin
        alu_ctrl = ALU_ADD;
        src_a    = 1'b1;
        src_b    = 1'b1;
      end
      OP_JALR: begin
        alu_ctrl = ALU_ADD;
        src_b    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for
// the multicycle RV32I core, with a sticky TRAP state for illegal
// instructions and memory handshake timeouts.
//
// Handshakes: imem_req / MemRead / MemWrite are held high for the whole wait
// state; the cycle in which the matching ready (imem_ready / dmem_ready) is
// high completes the transfer. Ready inputs are ignored in any other state.
//
// Ports: clk, rst_n (async active-low); imem_req/imem_ready/instr_rdata
// (fetch); dmem_ready (data access); branch_taken (datapath comparator);
// IRWrite, PCWrite, PCSrc, ALUSrc_A, ALUSrc_B, ALUControl, MemRead, MemWrite,
// MemtoReg, RegWrite (datapath control); state_o (debug), trap, trap_cause.
// Optional macro CU_PERF_CNT_EN adds cycle_cnt, instret_cnt and stall_cnt.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef CU_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr_rdata,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic [4:0]  ALUControl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic [2:0]  state_o,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef CU_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instret_cnt
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, next_state;
  logic [6:0] ir_op, ir_f7;
  logic [2:0] ir_f3;
  logic [7:0] wait_cnt;
  logic [1:0] cause_q, cause_d;
  logic [4:0] dec_alu;
  logic       dec_src_a, dec_src_b, dec_illegal;
  logic       is_load, is_store, is_branch, is_jal, is_jalr;
  logic       wait_stall, wait_last;

  // Only the decode fields are kept here; the datapath holds the full IR.
  logic unused_instr;
  assign unused_instr = ^{instr_rdata[24:15], instr_rdata[11:7]};

  alu_decoder u_alu_decoder (
    .opcode   (ir_op),
    .func7    (ir_f7),
    .func3    (ir_f3),
    .alu_ctrl (dec_alu),
    .src_a    (dec_src_a),
    .src_b    (dec_src_b),
    .illegal  (dec_illegal)
  );

  assign is_load   = (ir_op == OP_LOAD);
  assign is_store  = (ir_op == OP_STORE);
  assign is_branch = (ir_op == OP_BRANCH);
  assign is_jal    = (ir_op == OP_JAL);
  assign is_jalr   = (ir_op == OP_JALR);

  assign wait_stall = (state == S_FETCH && !imem_ready) ||
                      (state == S_MEM && !dmem_ready);
  assign wait_last  = (wait_cnt == WAIT_LAST);

  assign state_o    = state;
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ir_op    <= '0;
      ir_f7    <= '0;
      ir_f3    <= '0;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state   <= next_state;
      cause_q <= cause_d;
      if (IRWrite) begin
        ir_op <= instr_rdata[6:0];
        ir_f3 <= instr_rdata[14:12];
        ir_f7 <= instr_rdata[31:25];
      end
      if (next_state != state) wait_cnt <= '0;
      else if (wait_stall)     wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PCSRC_PC4;
    ALUSrc_A   = 1'b0;
    ALUSrc_B   = 1'b0;
    ALUControl = ALU_NOP;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = M2R_ALU;
    RegWrite   = 1'b0;

    // ALU setup is held steady from EXECUTE through WRITEBACK.
    if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
      ALUControl = dec_alu;
      ALUSrc_A   = dec_src_a;
      ALUSrc_B   = dec_src_b;
    end

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        // A ready in the last allowed cycle still wins over the timeout.
        if (imem_ready) begin
          IRWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_last) begin
          next_state = S_TRAP;
          cause_d    = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          next_state = S_TRAP;
          cause_d    = CAUSE_ILLEGAL;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          PCWrite    = 1'b1;
          PCSrc      = branch_taken ? PCSRC_BRANCH : PCSRC_PC4;
          next_state = S_FETCH;
        end else if (is_load || is_store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WRITEBACK;
        end
      end
      S_MEM: begin
        MemRead  = is_load;
        MemWrite = is_store;
        if (dmem_ready) begin
          if (is_load) begin
            next_state = S_WRITEBACK;
          end else begin
            PCWrite    = 1'b1;
            next_state = S_FETCH;
          end
        end else if (wait_last) begin
          next_state = S_TRAP;
          cause_d    = CAUSE_DMEM_TO;
        end
      end
      S_WRITEBACK: begin
        RegWrite   = 1'b1;
        MemtoReg   = is_load ? M2R_MEM : ((is_jal || is_jalr) ? M2R_PC4 : M2R_ALU);
        PCWrite    = 1'b1;
        PCSrc      = is_jal ? PCSRC_JAL : (is_jalr ? PCSRC_JALR : PCSRC_PC4);
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase

    // Strobes must drop the instant rst_n falls, before the registers clear.
    if (!rst_n) begin
      imem_req   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = PCSRC_PC4;
      ALUSrc_A   = 1'b0;
      ALUSrc_B   = 1'b0;
      ALUControl = ALU_NOP;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = M2R_ALU;
      RegWrite   = 1'b0;
    end
  end

`ifdef CU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (PCWrite)         instret_cnt <= instret_cnt + CNT_W'(1);
      if (wait_stall)      stall_cnt   <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequenced control unit for the multicycle RV32I core. It replaces single-cycle decode with an FSM that fetches, decodes, executes, accesses memory and writes back over several cycles. It handshakes with instruction and data memories that take a variable number of wait states. It detects illegal opcodes and memory timeouts, and sends the datapath to a sticky trap state on either.

Parameters:
MEM_TIMEOUT, 16, max wait cycles on any memory handshake before trap (range 2..255)
CNT_W, 32, width of performance counters (used only with CU_PERF_CNT_EN)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction fetch request, held until imem_ready
imem_ready  input  1  fetch data valid this cycle
instr_rdata  input  32  fetched instruction
dmem_ready  input  1  data access complete this cycle
branch_taken  input  1  branch comparator result from datapath
IRWrite  output  1  latch instr_rdata into IR (1-cycle pulse)
PCWrite  output  1  update PC using PCSrc (1-cycle pulse)
PCSrc  output  2  0 PC+4, 1 branch target, 2 JAL target, 3 JALR target
ALUSrc_A  output  1  0 rs1, 1 PC
ALUSrc_B  output  1  0 rs2, 1 imm
ALUControl  output  5  ALU op code (shared ALU_* encoding)
MemRead  output  1  load request, held until dmem_ready
MemWrite  output  1  store request, held until dmem_ready
MemtoReg  output  2  0 ALU, 1 mem data, 2 PC+4
RegWrite  output  1  register file write (1-cycle pulse)
state_o  output  3  current FSM state (debug)
trap  output  1  sticky fault indication
trap_cause  output  2  0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Reset values: FSM=FETCH, IR=0, wait counter=0. trap=0, trap_cause=0.
- All strobes and requests deassert during reset. ALUControl=ALU_NOP, PCSrc=0, MemtoReg=0.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH:
  - imem_req=1.
  - On imem_ready: IRWrite=1, go to DECODE.
  - Otherwise stay; wait counter increments.
- DECODE:
  - Opcode is outside {R, I-arith, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR} -> TRAP, cause 1.
  - Unsupported R-type func7/func3 combination -> TRAP, cause 1.
  - All other opcodes -> EXECUTE.
- EXECUTE:
  - ALUControl/ALUSrc_A/ALUSrc_B are decoded from the registered IR and held for EXECUTE, MEM and WRITEBACK.
  - BRANCH: ALU_SUB; PCWrite=1 with PCSrc = branch_taken ? 1 : 0; go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other opcodes: go to WRITEBACK.
- MEM:
  - MemRead (LOAD) or MemWrite (STORE) held until dmem_ready.
  - On ready, LOAD: go to WRITEBACK.
  - On ready, STORE: PCWrite=1, PCSrc=0, go to FETCH.
- WRITEBACK:
  - RegWrite=1.
  - MemtoReg: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - PCWrite=1 with PCSrc: 2 for JAL, 3 for JALR, 0 otherwise.
  - Go to FETCH.
- Latency with zero wait states: branch 3 cycles; R/I/U/JAL/JALR 4; store 4; load 5. Each wait state adds 1 cycle.
- Wait counter: clears on every state change. It counts only in FETCH and MEM while ready is low.
- Timeout: the counter reaches MEM_TIMEOUT-1 with ready still low -> TRAP, cause 2 (FETCH) or 3 (MEM). A ready arriving in that same cycle wins and there is no trap.
- TRAP: sticky until reset. trap=1 and all strobes/requests are 0.
- Reset mid-operation: any in-flight request drops immediately (asynchronous). No partial RegWrite or PCWrite may occur.
- Ready inputs are ignored outside their wait state.

Optional Feature:
CU_PERF_CNT_EN
- Defined:
  - Adds output cycle_cnt[CNT_W] (counts every non-reset cycle, frozen in TRAP).
  - Adds output instret_cnt[CNT_W] (increments on each retiring PCWrite).
  - Adds output stall_cnt[CNT_W] (increments on each wait-state cycle).
  - All three reset to 0 and wrap modulo 2^CNT_W.
- Undefined: none of these ports or logic exist.

Decomposition:
- Package cu_pkg holds:
  - state enum (3-bit);
  - OP_* opcode and ALU_* operation constants;
  - MemtoReg/PCSrc/trap_cause encodings.
- Sub-module alu_decoder: combinational mapping of {opcode, func7, func3} to ALUControl plus an illegal flag. Used in DECODE and EXECUTE.

Test Plan:
- ADD 0x002081B3, imem_ready same cycle -> states FETCH, DECODE, EXECUTE, WRITEBACK; ALUControl=ALU_ADD; RegWrite and PCWrite (PCSrc=0) in cycle 4.
- BEQ 0x00208463 with branch_taken=1 -> PCWrite with PCSrc=1 in cycle 3, RegWrite never asserted. Repeat with branch_taken=0 -> PCSrc=0.
- LW 0x0000A183, dmem_ready delayed 3 cycles -> MemRead held exactly 4 cycles, then WRITEBACK with MemtoReg=1; total latency 8.
- Instruction 0xFFFFFFFF -> TRAP after DECODE, trap_cause=1; no strobe asserts afterwards until rst_n is pulsed low.
- imem_ready held low, MEM_TIMEOUT=16 -> trap=1 with cause 2 on cycle 17. Separately, ready on cycle 16 -> no trap.
- With CU_PERF_CNT_EN: run ADD, SW, BEQ with zero wait states -> instret_cnt=3, cycle_cnt=11, stall_cnt=0.
